// File: rtl/booth_r4_mant_mul.sv
// Multi-cycle radix-4 Booth multiplier for unsigned FP32 significands.
// Retires one Booth digit per clock and produces the exact 2*AWIDTH-bit product.
// Valid/ready handshake on both sides; one operation in flight.
module booth_r4_mant_mul #(
  parameter int unsigned AWIDTH = 24,
  parameter int unsigned NDIG   = (AWIDTH + 2) / 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [AWIDTH-1:0]     a_mant,
  input  logic [AWIDTH-1:0]     b_mant,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*AWIDTH-1:0]   product,
  output logic                  busy
);

  localparam int unsigned PW   = 2 * AWIDTH;
  localparam int unsigned ACCW = 2 * AWIDTH + 4;
  localparam int unsigned YW   = AWIDTH + 3;
  localparam int unsigned CW   = $clog2(NDIG + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [ACCW-1:0] acc_q;      // two's-complement accumulator
  logic [ACCW-1:0] a_sh_q;     // multiplicand pre-shifted by 2*cnt
  logic [YW-1:0]   y_q;        // recoded multiplier, current triplet in [2:0]
  logic [CW-1:0]   cnt_q;
  logic [ACCW-1:0] term_c;
  logic [ACCW-1:0] acc_nxt_c;

  // Booth digit decode of the current triplet and partial-product accumulation
  always_comb begin
    term_c = '0;
    case (y_q[2:0])
      3'b001, 3'b010: term_c = a_sh_q;
      3'b011:         term_c = a_sh_q << 1;
      3'b100:         term_c = -(a_sh_q << 1);
      3'b101, 3'b110: term_c = -a_sh_q;
      default:        term_c = '0;
    endcase
    acc_nxt_c = acc_q + term_c;
  end

  // Control FSM, datapath registers and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      product   <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      a_sh_q    <= '0;
      y_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            a_sh_q   <= ACCW'(a_mant);
            y_q      <= {2'b00, b_mant, 1'b0};
            acc_q    <= '0;
            cnt_q    <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state_q  <= S_RUN;
          end
        end
        S_RUN: begin
          acc_q  <= acc_nxt_c;
          a_sh_q <= a_sh_q << 2;
          y_q    <= y_q >> 2;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CW'(NDIG - 1)) begin
            product   <= acc_nxt_c[PW-1:0];
            out_valid <= 1'b1;
            state_q   <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_r4_mant_mul.sv
// Self-checking bench for booth_r4_mant_mul: vector table plus handshake corner sequences.
module tb_booth_r4_mant_mul;

  localparam int AW   = 24;
  localparam int NDIG = 13;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [AW-1:0]   a_mant;
  logic [AW-1:0]   b_mant;
  logic            out_valid;
  logic            out_ready;
  logic [2*AW-1:0] product;
  logic            busy;

  booth_r4_mant_mul dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_mant    (a_mant),
    .b_mant    (b_mant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  typedef struct {
    logic [AW-1:0]   a;
    logic [AW-1:0]   b;
    logic [2*AW-1:0] p;
    int              stall;
    bit              early;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [2*AW-1:0] sb[$];
  vec_t vecs[8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands once in_ready is seen; the accept edge pushes the expected product.
  task automatic accept_op(input logic [AW-1:0] a, input logic [AW-1:0] b,
                           input logic [2*AW-1:0] p, input bit early);
    int cyc;
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      tick();
      cyc++;
    end
    if (!in_ready) chk("wait_in_ready", 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    a_mant    = a;
    b_mant    = b;
    out_ready = early;
    @(posedge clk);
    sb.push_back(p);
    #1;
    in_valid = 1'b0;
    a_mant   = 24'($urandom);
    b_mant   = 24'($urandom);
    chk("accept_in_ready", 64'(in_ready), 64'd0);
    chk("accept_busy", 64'(busy), 64'd1);
  endtask

  task automatic wait_out();
    int cyc;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("latency", 64'(cyc), 64'(NDIG));
  endtask

  task automatic check_product();
    logic [2*AW-1:0] exp;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      exp = sb.pop_front();
      chk("product", 64'(product), 64'(exp));
      chk("acc_guard", 64'(dut.acc_q[2*AW+3:2*AW]), 64'd0);
    end
  endtask

  task automatic finish_op(input int stall, input bit early);
    logic [2*AW-1:0] held;
    wait_out();
    check_product();
    if (!early) begin
      held = product;
      for (int s = 0; s < stall; s++) begin
        tick();
        chk("stall_out_valid", 64'(out_valid), 64'd1);
        chk("stall_product", 64'(product), 64'(held));
        chk("stall_in_ready", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
    end
    tick();
    out_ready = 1'b0;
    chk("release_out_valid", 64'(out_valid), 64'd0);
    chk("release_in_ready", 64'(in_ready), 64'd1);
    chk("release_busy", 64'(busy), 64'd0);
  endtask

  task automatic run_op(input logic [AW-1:0] a, input logic [AW-1:0] b,
                        input logic [2*AW-1:0] p, input int stall, input bit early);
    accept_op(a, b, p, early);
    finish_op(stall, early);
  endtask

  initial begin
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;

    vecs[0] = '{24'h800000, 24'h800000, 48'h400000000000, 0, 1'b0};
    vecs[1] = '{24'hF18000, 24'hE40000, 48'hD71600000000, 0, 1'b0};
    vecs[2] = '{24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, 0, 1'b0};
    vecs[3] = '{24'h000003, 24'h000005, 48'h00000000000F, 0, 1'b0};
    vecs[4] = '{24'h000000, 24'hABCDEF, 48'h000000000000, 0, 1'b0};
    vecs[5] = '{24'hC00000, 24'hC00000, 48'h900000000000, 5, 1'b0};
    vecs[6] = '{24'h000001, 24'hFFFFFF, 48'h000000FFFFFF, 2, 1'b0};
    vecs[7] = '{24'hFFFFFF, 24'h000002, 48'h000001FFFFFE, 0, 1'b1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_mant    = '0;
    b_mant    = '0;
    repeat (3) tick();
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_product", 64'(product), 64'd0);
    rst = 1'b0;

    // out_ready while idle must not create a result
    out_ready = 1'b1;
    repeat (2) tick();
    chk("idle_out_ready_ov", 64'(out_valid), 64'd0);
    chk("idle_out_ready_ir", 64'(in_ready), 64'd1);
    out_ready = 1'b0;

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].stall, vecs[i].early);

    for (int i = 0; i < 4; i++) begin
      ra = 24'($urandom) | 24'h800000;
      rb = 24'($urandom) | 24'h800000;
      run_op(ra, rb, 48'(ra) * 48'(rb), i, 1'b0);
    end

    // Back-to-back: new operands offered on the DONE->IDLE edge are taken one cycle later
    accept_op(24'h123456, 24'h000010, 48'h000001234560, 1'b0);
    wait_out();
    check_product();
    in_valid  = 1'b1;
    a_mant    = 24'hA00000;
    b_mant    = 24'h000003;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("b2b_out_valid", 64'(out_valid), 64'd0);
    chk("b2b_in_ready", 64'(in_ready), 64'd1);
    chk("b2b_busy", 64'(busy), 64'd0);
    accept_op(24'hA00000, 24'h000003, 48'h000001E00000, 1'b0);
    finish_op(0, 1'b0);

    // Abort during RUN at digit 6
    accept_op(24'h123456, 24'h000777, 48'h0, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    chk("abort_cnt", 64'(dut.cnt_q), 64'd6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    void'(sb.pop_back());
    chk("abort_run_out_valid", 64'(out_valid), 64'd0);
    chk("abort_run_in_ready", 64'(in_ready), 64'd1);
    chk("abort_run_busy", 64'(busy), 64'd0);
    run_op(24'h800000, 24'hC00000, 48'h600000000000, 0, 1'b0);

    // Abort while a result waits in DONE
    accept_op(24'h000007, 24'h000009, 48'h00000000003F, 1'b0);
    wait_out();
    check_product();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_done_out_valid", 64'(out_valid), 64'd0);
    chk("abort_done_product", 64'(product), 64'd0);
    chk("abort_done_in_ready", 64'(in_ready), 64'd1);
    run_op(24'hFFFFFF, 24'h800000, 48'h7FFFFF800000, 1, 1'b0);

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
